cam_operand_sequencer: RTL and testbench

Upstream driver for the 4-bit CAM adder. After reset it builds the 8-entry full-adder lookup table, presents it to the adder with a one-cycle `write_en` pulse, and then issues operand triples (a, b, c). Each triple is accepted over a valid/ready handshake and held stable for the adder's pipeline depth. The block is the only source of `write_en`, `data`, `a`, `b` and `c` for the adder.

---
 rtl/cam_alu_pkg.sv | 26 ++
 rtl/cam_operand_sequencer.sv | 136 +++++++++++++
 tb/tb_cam_operand_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_alu_pkg.sv
// Shared definitions for the CAM adder slice: default sizes, table entry type,
// sequencer state encoding and the full-adder table entry function.
package cam_alu_pkg;

    localparam int CAM_WIDTH_DEF = 4;
    localparam int NUM_CELL_DEF  = 8;

    typedef logic [1:0] cam_entry_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WRITE = 2'd1,
        READY = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    // idx = {a, b, c}; result is {carry, sum}
    function automatic cam_entry_t fa_entry(input logic [2:0] idx);
        logic s;
        logic cy;
        s  = ^idx;
        cy = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
        return {cy, s};
    endfunction

endpackage

// File: rtl/cam_operand_sequencer.sv
// Builds the full-adder CAM table, writes it to the adder once, then issues held
// operand triples. Optional macro CAM_TBL_PROG_EN adds a programmable shadow table.
module cam_operand_sequencer
    import cam_alu_pkg::*;
#(
    parameter int CAM_WIDTH   = CAM_WIDTH_DEF,
    parameter int NUM_CELL    = NUM_CELL_DEF,
    parameter int HOLD_CYCLES = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CAM_WIDTH-1:0]  in_a,
    input  logic [CAM_WIDTH-1:0]  in_b,
    input  logic [CAM_WIDTH-1:0]  in_c,
    input  logic                  reload,
`ifdef CAM_TBL_PROG_EN
    input  logic                  prog_we,
    input  logic [2:0]            prog_addr,
    input  logic [1:0]            prog_data,
`endif
    output logic                  write_en,
    output logic [NUM_CELL*2-1:0] data,
    output logic [CAM_WIDTH-1:0]  a,
    output logic [CAM_WIDTH-1:0]  b,
    output logic [CAM_WIDTH-1:0]  c,
    output logic                  op_done,
    output logic                  busy,
    output seq_state_t            state_dbg
);

    seq_state_t state;
    logic [2:0] fill_idx;
    logic [3:0] hold_cnt;
    logic       reload_pend;
    cam_entry_t tbl [NUM_CELL];
    cam_entry_t fill_src;

    // Handshake: a triple transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.
    assign in_ready  = (state == READY);
    assign busy      = (state != READY);
    assign write_en  = (state == WRITE);
    assign op_done   = (state == HOLD) && (hold_cnt == 4'd0);
    assign state_dbg = state;

    always_comb begin
        data = '0;
        for (int i = 0; i < NUM_CELL; i++) begin
            data[2*i +: 2] = tbl[i];
        end
    end

`ifdef CAM_TBL_PROG_EN
    cam_entry_t ptbl [NUM_CELL];

    // Shadow writes land any time outside FILL so a rebuild never sees a torn table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CELL; i++) begin
                ptbl[i] <= fa_entry(3'(i));
            end
        end else if (prog_we && (state != FILL)) begin
            ptbl[prog_addr] <= prog_data;
        end
    end

    assign fill_src = ptbl[fill_idx];
`else
    assign fill_src = fa_entry(fill_idx);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            fill_idx    <= 3'd0;
            hold_cnt    <= 4'd0;
            reload_pend <= 1'b0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            for (int i = 0; i < NUM_CELL; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    tbl[fill_idx] <= fill_src;
                    fill_idx      <= fill_idx + 3'd1;
                    if (fill_idx == 3'(NUM_CELL - 1)) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    state <= READY;
                end
                READY: begin
                    if (in_valid) begin
                        a        <= in_a;
                        b        <= in_b;
                        c        <= in_c;
                        hold_cnt <= 4'(HOLD_CYCLES - 1);
                        state    <= HOLD;
                        if (reload) begin
                            reload_pend <= 1'b1;
                        end
                    end else if (reload) begin
                        state    <= FILL;
                        fill_idx <= 3'd0;
                    end
                end
                HOLD: begin
                    if (reload) begin
                        reload_pend <= 1'b1;
                    end
                    if (hold_cnt == 4'd0) begin
                        if (reload_pend || reload) begin
                            state       <= FILL;
                            fill_idx    <= 3'd0;
                            reload_pend <= 1'b0;
                        end else begin
                            state <= READY;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_operand_sequencer.sv
// Directed self-checking bench for cam_operand_sequencer (default parameters);
// the programmable-table scenario is built only when CAM_TBL_PROG_EN is defined.
module tb_cam_operand_sequencer;
    import cam_alu_pkg::*;

    localparam int W  = 4;
    localparam int NC = 8;
    localparam int HC = 6;
    localparam logic [15:0] FA_TBL = 16'hE994;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b, in_c;
    logic          reload;
    logic          write_en;
    logic [2*NC-1:0] data;
    logic [W-1:0]  a, b, c;
    logic          op_done;
    logic          busy;
    seq_state_t    state_dbg;
`ifdef CAM_TBL_PROG_EN
    logic          prog_we;
    logic [2:0]    prog_addr;
    logic [1:0]    prog_data;
`endif

    int checks   = 0;
    int failures = 0;
    logic [3*W-1:0] exp_q[$];

    cam_operand_sequencer #(.CAM_WIDTH(W), .NUM_CELL(NC), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .reload(reload),
`ifdef CAM_TBL_PROG_EN
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
`endif
        .write_en(write_en), .data(data),
        .a(a), .b(b), .c(c),
        .op_done(op_done), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 (first cycle with rst low).
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; reload = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
`ifdef CAM_TBL_PROG_EN
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
`endif
        step();
        step();
    endtask

    // Expects to be called in FILL cycle 0; returns in the first READY cycle.
    task automatic check_startup(input string tag, input logic [15:0] exp_data,
                                 input int reload_at);
        for (int cyc = 0; cyc < 8; cyc++) begin
            checks++;
            if (state_dbg !== FILL || write_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s_fill cyc%0d: state=%0d we=%b rdy=%b busy=%b, want FILL we=0 rdy=0 busy=1",
                         tag, cyc, state_dbg, write_en, in_ready, busy);
            end
            reload = (cyc == reload_at);
            step();
        end
        reload = 1'b0;
        checks++;
        if (write_en !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_write: we=%b rdy=%b, want we=1 rdy=0", tag, write_en, in_ready);
        end
        checks++;
        if (data !== exp_data) begin
            failures++;
            $display("FAIL %s_data: data=%h want %h", tag, data, exp_data);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || write_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready: rdy=%b we=%b busy=%b, want rdy=1 we=0 busy=0",
                     tag, in_ready, write_en, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state_dbg !== FILL || write_en !== 1'b0 || in_ready !== 1'b0 ||
            op_done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: state=%0d we=%b rdy=%b done=%b busy=%b, want 0 0 0 0 1",
                     state_dbg, write_en, in_ready, op_done, busy);
        end
        checks++;
        if ({a, b, c} !== 12'h000 || data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data: abc=%h data=%h, want 000 0000", {a, b, c}, data);
        end
        rst = 1'b0;
    endtask

    task automatic test_startup();
        check_startup("startup", FA_TBL, -1);
    endtask

    task automatic test_single_op();
        in_valid = 1'b1; in_a = 4'h5; in_b = 4'h3; in_c = 4'h1;
        step();
        in_valid = 1'b0; in_a = 4'hA; in_b = 4'hC; in_c = 4'hE;
        for (int k = 10; k <= 15; k++) begin
            checks++;
            if ({a, b, c} !== 12'h531) begin
                failures++;
                $display("FAIL single_abc cyc%0d: abc=%h want 531", k, {a, b, c});
            end
            checks++;
            if (op_done !== (k == 15) || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL single_done cyc%0d: done=%b rdy=%b, want done=%b rdy=0",
                         k, op_done, in_ready, (k == 15));
            end
            step();
        end
        checks++;
        if (in_ready !== 1'b1 || op_done !== 1'b0) begin
            failures++;
            $display("FAIL single_ret: rdy=%b done=%b, want 1 0", in_ready, op_done);
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        int last_acc;
        accepts  = 0;
        last_acc = -1;
        exp_q.delete();
        for (int k = 0; k < 21; k++) begin
            in_valid = 1'b1;
            in_a = W'(k); in_b = W'(k + 3); in_c = W'(k + 7);
            checks++;
            if (in_ready === 1'b1 && write_en === 1'b1) begin
                failures++;
                $display("FAIL b2b_overlap k%0d: we and rdy both high", k);
            end
            if (in_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (k - last_acc != HC + 1) begin
                        failures++;
                        $display("FAIL b2b_gap: gap=%0d want %0d", k - last_acc, HC + 1);
                    end
                end
                accepts++;
                last_acc = k;
                exp_q.push_back({in_a, in_b, in_c});
            end
            step();
            if (exp_q.size() > 0) begin
                checks++;
                if ({a, b, c} !== exp_q[$]) begin
                    failures++;
                    $display("FAIL b2b_abc k%0d: abc=%h want %h", k, {a, b, c}, exp_q[$]);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (accepts != 3 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_count: accepts=%0d rdy=%b, want 3 1", accepts, in_ready);
        end
    endtask

    task automatic test_reload_with_handshake();
        int n;
        in_valid = 1'b1; reload = 1'b1; in_a = 4'h9; in_b = 4'h6; in_c = 4'hF;
        step();
        in_valid = 1'b0; reload = 1'b0;
        n = 1;
        while (op_done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != HC || {a, b, c} !== 12'h96F) begin
            failures++;
            $display("FAIL rlhs_done: done_cycle=%0d abc=%h, want %0d 96f", n, {a, b, c}, HC);
        end
        step();
        check_startup("rlhs", FA_TBL, -1);
    endtask

    task automatic test_reload_in_hold();
        in_valid = 1'b1; in_a = 4'h1; in_b = 4'h2; in_c = 4'h4;
        step();
        in_valid = 1'b0;
        step();
        step();
        reload = 1'b1;
        step();
        reload = 1'b0;
        step();
        step();
        checks++;
        if (op_done !== 1'b1) begin
            failures++;
            $display("FAIL rlhold_done: done=%b want 1", op_done);
        end
        step();
        // a reload strobed mid-FILL must be ignored
        check_startup("rlhold", FA_TBL, 3);
    endtask

    task automatic test_reload_idle();
        reload = 1'b1;
        step();
        reload = 1'b0;
        checks++;
        if (state_dbg !== FILL || busy !== 1'b1) begin
            failures++;
            $display("FAIL rlidle: state=%0d busy=%b, want FILL 1", state_dbg, busy);
        end
        check_startup("rlidle", FA_TBL, -1);
    endtask

`ifdef CAM_TBL_PROG_EN
    task automatic test_prog();
        prog_we = 1'b1; prog_addr = 3'd7; prog_data = 2'b00;
        step();
        prog_we = 1'b0;
        checks++;
        if (data !== FA_TBL) begin
            failures++;
            $display("FAIL prog_early: data=%h want %h", data, FA_TBL);
        end
        reload = 1'b1;
        step();
        reload = 1'b0;
        // writes offered during FILL are dropped
        prog_we = 1'b1; prog_addr = 3'd0; prog_data = 2'b11;
        check_startup("prog", 16'h2994, -1);
        prog_we = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_hold();
        do_reset();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) step();
        in_valid = 1'b1; in_a = 4'h7; in_b = 4'h8; in_c = 4'hB;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (write_en !== 1'b0 || op_done !== 1'b0 || {a, b, c} !== 12'h000) begin
            failures++;
            $display("FAIL rstmid_out: we=%b done=%b abc=%h, want 0 0 000", write_en, op_done, {a, b, c});
        end
        checks++;
        if (state_dbg !== FILL || data !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_state: state=%0d data=%h, want FILL 0000", state_dbg, data);
        end
        check_startup("rstmid", FA_TBL, -1);
    endtask

    initial begin
        test_reset();
        test_startup();
        test_single_op();
        test_back_to_back();
        test_reload_with_handshake();
        test_reload_in_hold();
        test_reload_idle();
`ifdef CAM_TBL_PROG_EN
        test_prog();
`endif
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
